// File: rtl/cnt_seg_pkg.sv
// Shared constants for the two-digit counter display: scan states, select
// patterns and the digit-to-segment table (active-low {dp,g,f,e,d,c,b,a}).
package cnt_seg_pkg;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_UNITS = 2'd1,
    S_TENS  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [1:0] SEL_NONE   = 2'b11;
  localparam logic [1:0] SEL_UNITS  = 2'b10;
  localparam logic [1:0] SEL_TENS   = 2'b01;
  // Any out-of-range digit decodes to blank; used to blank a leading zero.
  localparam logic [3:0] DIGIT_NONE = 4'hF;

  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/cnt_seg_driver_decode.sv
// Combinational digit-to-segment lookup; digits above 9 decode to blank.
module seg7_decode
  import cnt_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = seg_code(digit);

endmodule

// File: rtl/cnt_seg_driver.sv
// Two-digit multiplexed display driver for a 4-bit counter, plus a
// registered one-cycle pulse when the upstream counter wraps 15 -> 0.
module cnt_seg_driver
  import cnt_seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pi_cnt,
  output logic [7:0] po_seg,
  output logic [1:0] po_sel,
  output logic       po_wrap
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state, next_state;
  logic [3:0]       snap;
  logic [3:0]       prev;
  logic             enter_units;
  logic [3:0]       digit_src;
  logic             tens;
  logic [3:0]       units;
  logic [3:0]       dec_digit;
  logic [7:0]       dec_seg;
  logic [1:0]       sel_next;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_BLANK;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        S_BLANK: next_state = S_UNITS;
        S_UNITS: next_state = S_TENS;
        S_TENS:  next_state = S_UNITS;
        default: next_state = S_BLANK;
      endcase
    end
  end

  // The snapshot is taken on the edge entering S_UNITS; that same edge must
  // already display the new value, so the digit source bypasses the register.
  assign enter_units = (state != S_UNITS) && (next_state == S_UNITS);
  assign digit_src   = enter_units ? pi_cnt : snap;
  assign tens        = (digit_src >= 4'd10);
  assign units       = tens ? (digit_src - 4'd10) : digit_src;

  always_ff @(posedge clk) begin
    if (rst)              snap <= 4'd0;
    else if (enter_units) snap <= pi_cnt;
  end

  always_comb begin
    dec_digit = DIGIT_NONE;
    sel_next  = SEL_NONE;
    case (next_state)
      S_UNITS: begin
        dec_digit = units;
        sel_next  = SEL_UNITS;
      end
      S_TENS: begin
        dec_digit = tens ? 4'd1 : DIGIT_NONE;
        sel_next  = SEL_TENS;
      end
      default: begin
        dec_digit = DIGIT_NONE;
        sel_next  = SEL_NONE;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit (dec_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      po_seg <= SEG_BLANK;
      po_sel <= SEL_NONE;
    end else begin
      po_seg <= dec_seg;
      po_sel <= sel_next;
    end
  end

  // Wrap detect runs every cycle, independent of the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 4'd0;
      po_wrap <= 1'b0;
    end else begin
      prev    <= pi_cnt;
      po_wrap <= (pi_cnt == 4'd0) && (prev == 4'd15);
    end
  end

endmodule

// File: tb/tb_cnt_seg_driver.sv
// Directed bench for cnt_seg_driver with SCAN_DIV = 4: scan timing, digit
// codes, leading-zero blanking, snapshot stability, wrap pulse and reset.
module tb_cnt_seg_driver;

  logic       clk;
  logic       rst;
  logic [3:0] pi_cnt;
  logic [7:0] po_seg;
  logic [1:0] po_sel;
  logic       po_wrap;

  int checks = 0;
  int errors = 0;

  // Expected {sel, seg, wrap} per cycle.
  logic [10:0] exp_q[$];
  logic [10:0] exp;

  cnt_seg_driver #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .pi_cnt  (pi_cnt),
    .po_seg  (po_seg),
    .po_sel  (po_sel),
    .po_wrap (po_wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one cycle and land on the falling edge for sampling.
  task automatic tick_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_n(input logic [1:0] sel, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({sel, seg, 1'b0});
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pi_cnt = 4'd7;
    push_n(2'b11, 8'hFF, 5);
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL reset cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
    rst = 1'b0;
    push_n(2'b11, 8'hFF, 3);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL post_reset_blank cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_static_7();
    push_n(2'b10, 8'hF8, 4);
    push_n(2'b01, 8'hFF, 4);
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL static7 cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_two_digits();
    pi_cnt = 4'd13;
    push_n(2'b10, 8'hB0, 4);
    push_n(2'b01, 8'hF9, 4);
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL cnt13 cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
  endtask

  // Snapshot of 14 is taken on the first edge, so the display stays on 14
  // while the counter steps 15 -> 0 underneath it.
  task automatic test_wrap();
    pi_cnt = 4'd14;
    push_n(2'b10, 8'h99, 4);
    push_n(2'b01, 8'hF9, 4);
    exp_q[2][0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) pi_cnt = 4'd15;
      if (i == 2) pi_cnt = 4'd0;
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL wrap cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_snapshot();
    pi_cnt = 4'd3;
    push_n(2'b10, 8'hB0, 4);
    push_n(2'b01, 8'hFF, 4);
    push_n(2'b10, 8'h90, 4);
    push_n(2'b01, 8'hFF, 4);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) pi_cnt = 4'd9;
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL snapshot cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
  endtask

  // Reset two cycles into the tens slot; pi_cnt=15 during reset then 0 after
  // release must not look like a wrap.
  task automatic test_reset_mid_tens();
    push_n(2'b10, 8'h90, 4);
    push_n(2'b01, 8'hFF, 2);
    push_n(2'b11, 8'hFF, 4);
    push_n(2'b10, 8'hC0, 4);
    push_n(2'b01, 8'hFF, 4);
    push_n(2'b10, 8'hC0, 1);
    for (int i = 0; i < 19; i++) begin
      rst = 1'b0;
      if (i == 6) begin
        rst    = 1'b1;
        pi_cnt = 4'd15;
      end
      if (i == 7) pi_cnt = 4'd0;
      exp = exp_q.pop_front();
      tick_cyc();
      checks++;
      if ({po_sel, po_seg, po_wrap} !== exp) begin
        errors++;
        $display("FAIL reset_mid_tens cyc%0d: got sel=%b seg=%h wrap=%b, want sel=%b seg=%h wrap=%b",
                 i, po_sel, po_seg, po_wrap, exp[10:9], exp[8:1], exp[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    pi_cnt = 4'd0;
    test_reset();
    test_static_7();
    test_two_digits();
    test_wrap();
    test_snapshot();
    test_reset_mid_tens();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
